// File: rtl/hetero_axis_pkg.sv
// Shared types and constants for the heterogeneous AXI-Stream path blocks.
// Used by the dispatcher/merger pair and their helpers.
package hetero_axis_pkg;

    typedef enum logic [1:0] {
        ARB,
        FWD0,
        FWD1
    } merge_state_t;

    localparam logic ARB_RR    = 1'b0;
    localparam logic ARB_PRIO  = 1'b1;

    localparam logic SRC_PATH0 = 1'b0;
    localparam logic SRC_PATH1 = 1'b1;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered skid buffer for a flat AXI-Stream payload.
// in_ready depends only on occupancy, never on in_valid.
module axis_skid_buffer #(
    parameter int WIDTH = 38
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/packet_merger.sv
// Packet-atomic 2:1 AXI-Stream merger with RR / guarded-priority arbitration.
// Grants only at packet boundaries; source tag travels in tuser.
module packet_merger
    import hetero_axis_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   s_axis0_tdata,
    input  logic                    s_axis0_tvalid,
    input  logic                    s_axis0_tlast,
    input  logic [DATA_WIDTH/8-1:0] s_axis0_tkeep,
    output logic                    s_axis0_tready,
    input  logic [DATA_WIDTH-1:0]   s_axis1_tdata,
    input  logic                    s_axis1_tvalid,
    input  logic                    s_axis1_tlast,
    input  logic [DATA_WIDTH/8-1:0] s_axis1_tkeep,
    output logic                    s_axis1_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tuser,
    input  logic                    m_axis_tready,
    input  logic                    arb_mode,
    output logic [CNT_WIDTH-1:0]    pkt_cnt0,
    output logic [CNT_WIDTH-1:0]    pkt_cnt1
);

    localparam int KW = DATA_WIDTH / 8;
    localparam int SW = DATA_WIDTH + KW + 2;
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    merge_state_t   state;
    merge_state_t   state_next;
    logic           last_gnt;
    logic [7:0]     starve_cnt;
    logic           grant0;
    logic           grant1;
    logic           buf_ready;
    logic           buf_valid;
    logic [SW-1:0]  buf_in;
    logic [SW-1:0]  buf_out;
    logic           acc0;
    logic           acc1;
    logic           end0;
    logic           end1;
    logic           arb_req;

    assign s_axis0_tready = (state == FWD0) && buf_ready;
    assign s_axis1_tready = (state == FWD1) && buf_ready;
    assign acc0 = s_axis0_tready && s_axis0_tvalid;
    assign acc1 = s_axis1_tready && s_axis1_tvalid;
    assign end0 = acc0 && s_axis0_tlast;
    assign end1 = acc1 && s_axis1_tlast;
    assign arb_req = (state == ARB) && (s_axis0_tvalid || s_axis1_tvalid);

    always_comb begin
        state_next = state;
        grant0     = 1'b0;
        grant1     = 1'b0;
        unique case (state)
            ARB: begin
                if (s_axis0_tvalid || s_axis1_tvalid) begin
                    if (arb_mode == ARB_PRIO) begin
                        // path1 first unless path0 has waited out its limit
                        grant1 = s_axis1_tvalid &&
                                 !(s_axis0_tvalid && starve_cnt == LIMIT);
                        grant0 = !grant1;
                    end else if (s_axis0_tvalid && s_axis1_tvalid) begin
                        grant0 = (last_gnt == SRC_PATH1);
                        grant1 = !grant0;
                    end else begin
                        grant0 = s_axis0_tvalid;
                        grant1 = s_axis1_tvalid;
                    end
                    state_next = grant1 ? FWD1 : FWD0;
                end
            end
            FWD0: begin
                if (end0) state_next = ARB;
            end
            FWD1: begin
                if (end1) state_next = ARB;
            end
            default: state_next = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt   <= SRC_PATH1;
            starve_cnt <= 8'd0;
            pkt_cnt0   <= '0;
            pkt_cnt1   <= '0;
        end else begin
            if (end0) last_gnt <= SRC_PATH0;
            if (end1) last_gnt <= SRC_PATH1;
            if (end0 && pkt_cnt0 != '1) pkt_cnt0 <= pkt_cnt0 + 1'b1;
            if (end1 && pkt_cnt1 != '1) pkt_cnt1 <= pkt_cnt1 + 1'b1;
            if (arb_req) begin
                if (grant1 && s_axis0_tvalid) begin
                    if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 8'd1;
                end else begin
                    starve_cnt <= 8'd0;
                end
            end
        end
    end

    always_comb begin
        buf_valid = 1'b0;
        buf_in    = {s_axis0_tdata, s_axis0_tkeep, s_axis0_tlast, SRC_PATH0};
        if (state == FWD0) begin
            buf_valid = s_axis0_tvalid;
        end else if (state == FWD1) begin
            buf_valid = s_axis1_tvalid;
            buf_in    = {s_axis1_tdata, s_axis1_tkeep, s_axis1_tlast, SRC_PATH1};
        end
    end

    axis_skid_buffer #(
        .WIDTH(SW)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (buf_in),
        .in_valid (buf_valid),
        .in_ready (buf_ready),
        .out_data (buf_out),
        .out_valid(m_axis_tvalid),
        .out_ready(m_axis_tready)
    );

    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} = buf_out;

endmodule

// File: tb/tb_packet_merger.sv
// Directed bench for packet_merger: arbitration, atomicity, backpressure,
// asynchronous reset and counter saturation.
module tb_packet_merger;

    localparam int DW = 32;
    localparam int KW = DW / 8;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] s0_tdata = '0;
    logic          s0_tvalid = 1'b0;
    logic          s0_tlast = 1'b0;
    logic [KW-1:0] s0_tkeep = '1;
    logic          s0_tready;
    logic [DW-1:0] s1_tdata = '0;
    logic          s1_tvalid = 1'b0;
    logic          s1_tlast = 1'b0;
    logic [KW-1:0] s1_tkeep = '1;
    logic          s1_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tlast;
    logic [KW-1:0] m_tkeep;
    logic          m_tuser;
    logic          m_tready = 1'b1;
    logic          arb_mode = 1'b0;
    logic [15:0]   cnt0;
    logic [15:0]   cnt1;

    logic          x_s0_tready;
    logic          x_s1_tready;
    logic [DW-1:0] x_tdata;
    logic          x_tvalid;
    logic          x_tlast;
    logic [KW-1:0] x_tkeep;
    logic          x_tuser;
    logic [1:0]    x_cnt0;
    logic [1:0]    x_cnt1;

    beat_t         q0[$];
    beat_t         q1[$];
    logic [DW-1:0] od[$];
    logic          ou[$];
    logic          ol[$];
    int            oc[$];
    int            ic0[$];
    int            cyc = 0;
    int            in0_hs = 0;
    int            stab_err = 0;
    int            s1_leak = 0;
    bit            bp_en = 1'b0;
    bit            watch1 = 1'b0;
    bit            stall = 1'b0;
    logic [DW-1:0] pd;
    logic          pl;
    logic          pu;
    int            tests = 0;
    int            fails = 0;

    always #5 clk = ~clk;

    packet_merger #(
        .DATA_WIDTH(DW), .STARVE_LIMIT(4), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis0_tdata(s0_tdata), .s_axis0_tvalid(s0_tvalid),
        .s_axis0_tlast(s0_tlast), .s_axis0_tkeep(s0_tkeep),
        .s_axis0_tready(s0_tready),
        .s_axis1_tdata(s1_tdata), .s_axis1_tvalid(s1_tvalid),
        .s_axis1_tlast(s1_tlast), .s_axis1_tkeep(s1_tkeep),
        .s_axis1_tready(s1_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid),
        .m_axis_tlast(m_tlast), .m_axis_tkeep(m_tkeep),
        .m_axis_tuser(m_tuser), .m_axis_tready(m_tready),
        .arb_mode(arb_mode), .pkt_cnt0(cnt0), .pkt_cnt1(cnt1)
    );

    // narrow-counter copy sees identical stimulus; only its counters are read
    packet_merger #(
        .DATA_WIDTH(DW), .STARVE_LIMIT(4), .CNT_WIDTH(2)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .s_axis0_tdata(s0_tdata), .s_axis0_tvalid(s0_tvalid),
        .s_axis0_tlast(s0_tlast), .s_axis0_tkeep(s0_tkeep),
        .s_axis0_tready(x_s0_tready),
        .s_axis1_tdata(s1_tdata), .s_axis1_tvalid(s1_tvalid),
        .s_axis1_tlast(s1_tlast), .s_axis1_tkeep(s1_tkeep),
        .s_axis1_tready(x_s1_tready),
        .m_axis_tdata(x_tdata), .m_axis_tvalid(x_tvalid),
        .m_axis_tlast(x_tlast), .m_axis_tkeep(x_tkeep),
        .m_axis_tuser(x_tuser), .m_axis_tready(m_tready),
        .arb_mode(arb_mode), .pkt_cnt0(x_cnt0), .pkt_cnt1(x_cnt1)
    );

    always @(posedge clk) begin
        if (rst_n) begin
            if (m_tvalid && m_tready) begin
                od.push_back(m_tdata);
                ou.push_back(m_tuser);
                ol.push_back(m_tlast);
                oc.push_back(cyc);
            end
            if (s0_tvalid && s0_tready && q0.size() > 0) begin
                void'(q0.pop_front());
                ic0.push_back(cyc);
                in0_hs++;
            end
            if (s1_tvalid && s1_tready && q1.size() > 0) begin
                void'(q1.pop_front());
            end
            if (stall && !(m_tvalid && m_tdata == pd &&
                           m_tlast == pl && m_tuser == pu)) begin
                stab_err++;
            end
            stall = m_tvalid && !m_tready;
            pd = m_tdata;
            pl = m_tlast;
            pu = m_tuser;
        end else begin
            stall = 1'b0;
        end
        cyc++;
    end

    always @(negedge clk) begin
        s0_tvalid = q0.size() > 0;
        s0_tdata  = s0_tvalid ? q0[0].d : '0;
        s0_tlast  = s0_tvalid ? q0[0].l : 1'b0;
        s1_tvalid = q1.size() > 0;
        s1_tdata  = s1_tvalid ? q1[0].d : '0;
        s1_tlast  = s1_tvalid ? q1[0].l : 1'b0;
        m_tready  = bp_en ? 1'($urandom % 2) : 1'b1;
        if (watch1 && in0_hs < 16 && s1_tready) s1_leak++;
    end

    task automatic clear_logs;
        od.delete();
        ou.delete();
        ol.delete();
        oc.delete();
        ic0.delete();
        in0_hs = 0;
        stab_err = 0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        clear_logs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic push_pkt(input int path, input int n, input int base);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.d = DW'(base + i);
            b.l = (i == n - 1);
            if (path == 0) q0.push_back(b);
            else q1.push_back(b);
        end
    endtask

    task automatic wait_out(input int n, input int budget, output bit ok);
        int k;
        k = 0;
        while (od.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        ok = (od.size() >= n);
    endtask

    task automatic test_reset;
        do_reset();
        tests++;
        if (m_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL reset_tvalid got=%b exp=0", m_tvalid);
        end
        tests++;
        if (s0_tready !== 1'b0 || s1_tready !== 1'b0) begin
            fails++;
            $display("FAIL reset_tready got=%b%b exp=00", s0_tready, s1_tready);
        end
        tests++;
        if (cnt0 !== 16'd0 || cnt1 !== 16'd0) begin
            fails++;
            $display("FAIL reset_cnt got=%0d/%0d exp=0/0", cnt0, cnt1);
        end
        tests++;
        if (m_tdata !== '0 || m_tkeep !== '0 ||
            m_tlast !== 1'b0 || m_tuser !== 1'b0) begin
            fails++;
            $display("FAIL reset_payload got=%h/%h/%b/%b exp=0",
                     m_tdata, m_tkeep, m_tlast, m_tuser);
        end
    endtask

    task automatic test_rr;
        bit ok;
        int p;
        int b;
        logic [DW-1:0] exp;
        do_reset();
        arb_mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_pkt(0, 3, i * 16);
            push_pkt(1, 3, 256 + i * 16);
        end
        wait_out(24, 300, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL rr_timeout got=%0d beats exp=24", od.size());
        end else begin
            for (int i = 0; i < 24; i++) begin
                p = i / 3;
                b = i % 3;
                exp = DW'((p % 2) * 256 + (p / 2) * 16 + b);
                tests++;
                if (od[i] !== exp || ou[i] !== 1'(p % 2) || ol[i] !== (b == 2)) begin
                    fails++;
                    $display("FAIL rr_beat%0d got=%h/%b/%b exp=%h/%b/%b",
                             i, od[i], ou[i], ol[i], exp, 1'(p % 2), b == 2);
                end
            end
            for (int k = 0; k < 7; k++) begin
                tests++;
                if (oc[3 * k + 3] - oc[3 * k + 2] !== 2 ||
                    oc[3 * k + 2] - oc[3 * k] !== 2) begin
                    fails++;
                    $display("FAIL rr_gap%0d got=%0d exp=2",
                             k, oc[3 * k + 3] - oc[3 * k + 2]);
                end
            end
            tests++;
            if (oc[0] !== ic0[0] + 1) begin
                fails++;
                $display("FAIL rr_latency got=%0d exp=%0d", oc[0], ic0[0] + 1);
            end
        end
        tests++;
        if (cnt0 !== 16'd4 || cnt1 !== 16'd4) begin
            fails++;
            $display("FAIL rr_cnt got=%0d/%0d exp=4/4", cnt0, cnt1);
        end
    endtask

    task automatic test_prio;
        bit ok;
        logic [9:0] seq;
        seq = 10'b1111011110;
        do_reset();
        arb_mode = 1'b1;
        for (int i = 0; i < 2; i++) push_pkt(0, 1, i);
        for (int i = 0; i < 8; i++) push_pkt(1, 1, 256 + i);
        wait_out(10, 200, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL prio_timeout got=%0d beats exp=10", od.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                tests++;
                if (ou[i] !== seq[9 - i]) begin
                    fails++;
                    $display("FAIL prio_grant%0d got=%b exp=%b", i, ou[i], seq[9 - i]);
                end
            end
        end
        tests++;
        if (cnt0 !== 16'd2 || cnt1 !== 16'd8) begin
            fails++;
            $display("FAIL prio_cnt got=%0d/%0d exp=2/8", cnt0, cnt1);
        end
        arb_mode = 1'b0;
    endtask

    task automatic test_backpressure;
        bit ok;
        do_reset();
        s1_leak = 0;
        bp_en = 1'b1;
        watch1 = 1'b1;
        push_pkt(0, 16, 0);
        repeat (3) @(negedge clk);
        push_pkt(1, 2, 'h200);
        wait_out(18, 600, ok);
        bp_en = 1'b0;
        watch1 = 1'b0;
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL bp_timeout got=%0d beats exp=18", od.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                tests++;
                if (od[i] !== DW'(i) || ou[i] !== 1'b0 || ol[i] !== (i == 15)) begin
                    fails++;
                    $display("FAIL bp_beat%0d got=%h/%b/%b exp=%h/0/%b",
                             i, od[i], ou[i], ol[i], DW'(i), i == 15);
                end
            end
            tests++;
            if (od[16] !== 32'h200 || ou[16] !== 1'b1 || od[17] !== 32'h201) begin
                fails++;
                $display("FAIL bp_path1 got=%h/%b/%h exp=200/1/201",
                         od[16], ou[16], od[17]);
            end
        end
        tests++;
        if (s1_leak !== 0) begin
            fails++;
            $display("FAIL bp_s1_tready got=%0d cycles exp=0", s1_leak);
        end
        tests++;
        if (stab_err !== 0) begin
            fails++;
            $display("FAIL bp_stable got=%0d changes exp=0", stab_err);
        end
    endtask

    task automatic test_atomic;
        bit ok;
        do_reset();
        push_pkt(0, 6, 'h40);
        wait_out(2, 100, ok);
        push_pkt(1, 2, 'h300);
        wait_out(8, 200, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL atomic_timeout got=%0d beats exp=8", od.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                tests++;
                if (ou[i] !== (i >= 6)) begin
                    fails++;
                    $display("FAIL atomic_src%0d got=%b exp=%b", i, ou[i], i >= 6);
                end
            end
            tests++;
            if (ol[5] !== 1'b1 || oc[6] <= oc[5] || od[6] !== 32'h300) begin
                fails++;
                $display("FAIL atomic_order got=%b/%0d/%0d/%h exp=1/later/300",
                         ol[5], oc[5], oc[6], od[6]);
            end
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int k;
        do_reset();
        push_pkt(0, 1, 'h11);
        wait_out(1, 50, ok);
        tests++;
        if (!ok || cnt0 !== 16'd1) begin
            fails++;
            $display("FAIL rmid_pre got=%0d exp=1", cnt0);
        end
        push_pkt(0, 5, 'h50);
        k = 0;
        while (in0_hs < 3 && k < 50) begin
            @(negedge clk);
            k++;
        end
        tests++;
        if (m_tvalid !== 1'b1) begin
            fails++;
            $display("FAIL rmid_busy got=%b exp=1", m_tvalid);
        end
        #1;
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        #1;
        tests++;
        if (m_tvalid !== 1'b0 || s0_tready !== 1'b0) begin
            fails++;
            $display("FAIL rmid_async got=%b/%b exp=0/0", m_tvalid, s0_tready);
        end
        tests++;
        if (cnt0 !== 16'd0 || cnt1 !== 16'd0) begin
            fails++;
            $display("FAIL rmid_cnt got=%0d/%0d exp=0/0", cnt0, cnt1);
        end
        repeat (2) @(negedge clk);
        clear_logs();
        rst_n = 1'b1;
        @(negedge clk);
        push_pkt(0, 3, 'h70);
        wait_out(3, 100, ok);
        repeat (4) @(negedge clk);
        tests++;
        if (!ok || od.size() !== 3) begin
            fails++;
            $display("FAIL rmid_after got=%0d beats exp=3", od.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (od[i] !== DW'('h70 + i) || ol[i] !== (i == 2)) begin
                    fails++;
                    $display("FAIL rmid_beat%0d got=%h/%b exp=%h/%b",
                             i, od[i], ol[i], DW'('h70 + i), i == 2);
                end
            end
        end
    endtask

    task automatic test_saturation;
        bit ok;
        do_reset();
        for (int i = 0; i < 5; i++) push_pkt(0, 1, i);
        wait_out(5, 100, ok);
        @(negedge clk);
        tests++;
        if (!ok || x_cnt0 !== 2'd3) begin
            fails++;
            $display("FAIL sat_cnt2 got=%0d exp=3", x_cnt0);
        end
        tests++;
        if (cnt0 !== 16'd5) begin
            fails++;
            $display("FAIL sat_cnt16 got=%0d exp=5", cnt0);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_rr();
        test_prio();
        test_backpressure();
        test_atomic();
        test_reset_mid();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
